// File: rtl/clk_div_ctrl.sv
// Divider-update controller: arbitrates two requesters, waits for the divided clock to be low,
// applies the new divide value with a one-cycle divider reset, settles, then acks.
// Optional WAIT_LOW watchdog is enabled by defining CLK_DIV_CTRL_TIMEOUT_EN.
module clk_div_ctrl #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter logic [3:0]  RESET_DIV  = 4'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [3:0] div0,
    input  logic [3:0] div1,
    input  logic       clk_div_mon,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic [3:0] div_cfg,
    output logic       div_rst,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_LOW = 3'd1,
        APPLY    = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e     state_q;
    logic       rr_q;
    logic [3:0] val_q;
    logic [3:0] settle_cnt_q;
    logic [1:0] gnt_q;
    logic [1:0] ack_q;
    logic [3:0] div_cfg_q;
    logic       div_rst_q;
    logic       busy_q;

    logic       pick_d;
    logic [3:0] req_val_d;
    logic [3:0] val_d;
    logic [1:0] gnt_d;
    logic       apply_d;

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam logic [4:0] WAIT_LAST = 5'd31;
    logic [4:0] wait_cnt_q;
    logic       timeout_q;
    logic       wd_expired_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // A lone requester wins outright; the round-robin pointer only breaks ties.
    always_comb begin
        pick_d = rr_q;
        if (req == 2'b01) begin
            pick_d = 1'b0;
        end else if (req == 2'b10) begin
            pick_d = 1'b1;
        end
        req_val_d = pick_d ? div1 : div0;
        val_d     = (req_val_d < 4'd2) ? 4'd2 : req_val_d;
        gnt_d     = pick_d ? 2'b10 : 2'b01;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        wd_expired_d = clk_div_mon && (wait_cnt_q == WAIT_LAST);
        apply_d      = !clk_div_mon || wd_expired_d;
`else
        apply_d      = !clk_div_mon;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            val_q        <= RESET_DIV;
            settle_cnt_q <= '0;
            gnt_q        <= 2'b00;
            ack_q        <= 2'b00;
            div_cfg_q    <= RESET_DIV;
            div_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            ack_q     <= 2'b00;
            div_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        // Pointer moves on every grant, including uncontested ones.
                        rr_q   <= ~rr_q;
                        val_q  <= val_d;
                        gnt_q  <= gnt_d;
                        busy_q <= 1'b1;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                        wait_cnt_q <= '0;
                        timeout_q  <= 1'b0;
`endif
                        if (val_d == div_cfg_q) begin
                            state_q <= DONE;
                            ack_q   <= gnt_d;
                        end else begin
                            state_q <= WAIT_LOW;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (apply_d) begin
                        state_q   <= APPLY;
                        div_cfg_q <= val_q;
                        div_rst_q <= 1'b1;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                        if (wd_expired_d) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 5'd1;
`endif
                    end
                end
                APPLY: begin
                    state_q      <= SETTLE;
                    settle_cnt_q <= SETTLE_LAST;
                end
                SETTLE: begin
                    if (settle_cnt_q == 4'd0) begin
                        state_q <= DONE;
                        ack_q   <= gnt_q;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign div_cfg = div_cfg_q;
    assign div_rst = div_rst_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios with literal expectations plus randomized
// two-requester traffic, all checked every cycle against a timestamp-based reference model.
module tb_clk_div_ctrl;

    localparam int SETTLE = 4;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] div0;
    logic [3:0] div1;
    logic       clk_div_mon;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [3:0] div_cfg;
    logic       div_rst;
    logic       busy;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: an operation is tracked by the edge numbers of its grant, apply and done.
    int         edgeNo;
    bit         mActive;
    bit         mWho;
    bit         rrPtr;
    logic [3:0] mVal;
    int         mGrant;
    int         mApply;
    int         mDone;
    logic [1:0] expGnt;
    logic [1:0] expAck;
    logic [3:0] expDivCfg;
    logic       expDivRst;
    logic       expBusy;
    logic       expTimeout;

    logic [1:0] ackArr  [0:63];
    logic [1:0] gntArr  [0:63];
    logic [3:0] cfgArr  [0:63];
    logic       rstArr  [0:63];
    logic       toArr   [0:63];

    clk_div_ctrl #(
        .SETTLE_CYC (SETTLE),
        .RESET_DIV  (4'd2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .div0        (div0),
        .div1        (div1),
        .clk_div_mon (clk_div_mon),
        .gnt         (gnt),
        .ack         (ack),
        .div_cfg     (div_cfg),
        .div_rst     (div_rst),
        .busy        (busy),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mActive    = 1'b0;
        mWho       = 1'b0;
        rrPtr      = 1'b0;
        mVal       = 4'd2;
        mGrant     = -100;
        mApply     = -100;
        mDone      = -100;
        expGnt     = 2'b00;
        expAck     = 2'b00;
        expDivCfg  = 4'd2;
        expDivRst  = 1'b0;
        expBusy    = 1'b0;
        expTimeout = 1'b0;
    endtask

    task automatic modelStep();
        edgeNo++;
        expAck    = 2'b00;
        expDivRst = 1'b0;
        if (mActive) begin
            if (mApply < 0 && edgeNo > mGrant) begin
                if (!clk_div_mon) begin
                    mApply = edgeNo;
                end else if (TO_EN && (edgeNo - mGrant == 32)) begin
                    mApply     = edgeNo;
                    expTimeout = 1'b1;
                end
                if (mApply == edgeNo) begin
                    expDivCfg = mVal;
                    expDivRst = 1'b1;
                    mDone     = edgeNo + 1 + SETTLE;
                end
            end
            if (edgeNo == mDone) expAck = expGnt;
            if (edgeNo == mDone + 1) begin
                mActive = 1'b0;
                expGnt  = 2'b00;
                expBusy = 1'b0;
            end
        end else if (req != 2'b00) begin
            mWho       = (req == 2'b11) ? rrPtr : req[1];
            rrPtr      = ~rrPtr;
            mVal       = mWho ? div1 : div0;
            if (mVal < 4'd2) mVal = 4'd2;
            mActive    = 1'b1;
            mGrant     = edgeNo;
            mApply     = -1;
            mDone      = -100;
            expGnt     = 2'b01 << mWho;
            expBusy    = 1'b1;
            expTimeout = 1'b0;
            if (mVal == expDivCfg) begin
                mApply = edgeNo;
                mDone  = edgeNo;
                expAck = expGnt;
            end
        end
    endtask

    initial begin
        edgeNo = 0;
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Every cycle, compare all outputs with the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("gnt", int'(gnt), int'(expGnt));
            checkOutput("ack", int'(ack), int'(expAck));
            checkOutput("div_cfg", int'(div_cfg), int'(expDivCfg));
            checkOutput("div_rst", int'(div_rst), int'(expDivRst));
            checkOutput("busy", int'(busy), int'(expBusy));
            checkOutput("timeout", int'(timeout), int'(expTimeout));
            checkOutput("gntOneHot", int'($onehot0(gnt)), 1);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepToDrive();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                                 input logic mon);
        req         = r;
        div0        = d0;
        div1        = d1;
        clk_div_mon = mon;
    endtask

    task automatic doReset();
        stepToDrive();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Records outputs for cycles 1..n after a request was driven in cycle 0.
    task automatic recordOp(input int n, input int monLowAt);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ackArr[k] = ack;
            gntArr[k] = gnt;
            cfgArr[k] = div_cfg;
            rstArr[k] = div_rst;
            toArr[k]  = timeout;
            #1;
            req = req & ~ack;
            if (k == monLowAt) clk_div_mon = 1'b0;
        end
    endtask

    task automatic waitAck(input int limit, output logic [1:0] seen);
        seen = 2'b00;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                seen = ack;
                break;
            end
        end
        checkOutput("ackSeen", int'(seen != 2'b00), 1);
        #1;
    endtask

    task automatic randomTraffic(input int cycles);
        bit pend [2];
        int monRun;
        pend[0]     = 1'b0;
        pend[1]     = 1'b0;
        monRun      = 0;
        clk_div_mon = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            stepToDrive();
            if (c == cycles / 2) begin
                rst_n   = 1'b0;
                req     = 2'b00;
                pend[0] = 1'b0;
                pend[1] = 1'b0;
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    req[i]  = 1'b0;
                    pend[i] = 1'b0;
                end else if (req[i] && gnt[i]) begin
                    pend[i] = 1'b1;
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else if (!req[i] && !pend[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    if (i == 0) div0 = 4'($urandom_range(0, 15));
                    else        div1 = 4'($urandom_range(0, 15));
                end
            end
            if (monRun == 0) begin
                clk_div_mon = ~clk_div_mon;
                if (TO_EN && clk_div_mon && $urandom_range(0, 7) == 0)
                    monRun = int'($urandom_range(20, 45));
                else
                    monRun = int'($urandom_range(1, 5));
            end else begin
                monRun--;
            end
        end
        req = 2'b00;
        repeat (60) @(negedge clk);
    endtask

    initial begin
        logic [1:0] seen;
        int         cnt;
        rst_n = 1'b0;
        applyStimulus(2'b00, 4'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstGnt", int'(gnt), 0);
        checkOutput("rstDivCfg", int'(div_cfg), 2);
        checkOutput("rstBusy", int'(busy), 0);
        rst_n = 1'b1;

        // New value with the divided clock already low.
        stepToDrive();
        applyStimulus(2'b01, 4'd6, 4'd0, 1'b0);
        recordOp(9, -1);
        checkOutput("aGntC1", int'(gntArr[1]), 1);
        checkOutput("aCfgC1", int'(cfgArr[1]), 2);
        checkOutput("aRstC1", int'(rstArr[1]), 0);
        checkOutput("aRstC2", int'(rstArr[2]), 1);
        checkOutput("aCfgC2", int'(cfgArr[2]), 6);
        checkOutput("aRstC3", int'(rstArr[3]), 0);
        checkOutput("aAckC6", int'(ackArr[6]), 0);
        checkOutput("aAckC7", int'(ackArr[7]), 1);
        checkOutput("aGntC8", int'(gntArr[8]), 0);

        // Simultaneous requests from reset: requester 0 first, then 1.
        doReset();
        stepToDrive();
        applyStimulus(2'b11, 4'd5, 4'd9, 1'b0);
        waitAck(60, seen);
        checkOutput("bFirstAck", int'(seen), 1);
        req[0] = 1'b0;
        waitAck(60, seen);
        checkOutput("bSecondAck", int'(seen), 2);
        req[1] = 1'b0;
        checkOutput("bFinalCfg", int'(div_cfg), 9);

        // Clamped value equal to the current divide: immediate ack, no divider reset.
        doReset();
        stepToDrive();
        applyStimulus(2'b10, 4'd0, 4'd1, 1'b1);
        recordOp(4, -1);
        checkOutput("cAckC1", int'(ackArr[1]), 2);
        checkOutput("cGntC1", int'(gntArr[1]), 2);
        cnt = 0;
        for (int k = 1; k <= 4; k++) cnt += int'(rstArr[k]);
        checkOutput("cNoDivRst", cnt, 0);
        checkOutput("cCfgC4", int'(cfgArr[4]), 2);

        // Divided clock high for a while, then low.
        doReset();
        stepToDrive();
        applyStimulus(2'b01, 4'd7, 4'd0, 1'b1);
        recordOp(20, 11);
        cnt = 0;
        for (int k = 1; k <= 20; k++) cnt += int'(rstArr[k]);
        checkOutput("dRstC11", int'(rstArr[11]), 0);
        checkOutput("dRstC12", int'(rstArr[12]), 1);
        checkOutput("dRstCount", cnt, 1);
        checkOutput("dAckC17", int'(ackArr[17]), 1);

        // Reset while settling: immediate reset values and no ack afterwards.
        doReset();
        stepToDrive();
        applyStimulus(2'b01, 4'd6, 4'd0, 1'b0);
        recordOp(4, -1);
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        checkOutput("eGnt", int'(gnt), 0);
        checkOutput("eDivCfg", int'(div_cfg), 2);
        checkOutput("eBusy", int'(busy), 0);
        checkOutput("eDivRst", int'(div_rst), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        recordOp(10, -1);
        cnt = 0;
        for (int k = 1; k <= 10; k++) cnt += int'(ackArr[k] != 2'b00);
        checkOutput("eNoAck", cnt, 0);

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        // Divided clock stuck high: watchdog forces the apply and flags timeout.
        doReset();
        stepToDrive();
        applyStimulus(2'b01, 4'd8, 4'd0, 1'b1);
        recordOp(40, -1);
        checkOutput("fRstC32", int'(rstArr[32]), 0);
        checkOutput("fRstC33", int'(rstArr[33]), 1);
        checkOutput("fToC32", int'(toArr[32]), 0);
        checkOutput("fToC33", int'(toArr[33]), 1);
        checkOutput("fAckC38", int'(ackArr[38]), 1);
        checkOutput("fToC40", int'(toArr[40]), 1);
        stepToDrive();
        applyStimulus(2'b10, 4'd8, 4'd3, 1'b0);
        checkOutput("fToBeforeGrant", int'(timeout), 1);
        recordOp(12, -1);
        checkOutput("fToAfterGrant", int'(toArr[1]), 0);
`endif

        doReset();
        randomTraffic(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
